bcd_alarm_clock_core: RTL and testbench
=======================================

Name: bcd_alarm_clock_core

Overview:
- Self-contained hardware time-of-day clock with alarm. Replaces software timekeeping in the Nios-based clock system.
- Takes raw push-buttons and switches as inputs.
- Produces six BCD digits (HH:MM:SS) for the seven-segment decoders, per-digit blank flags, and a parametrised-width buzzer drive.
- Adds debouncing, set modes, 12/24 h display, an alarm with timeout, and field blinking.

Parameters:
- TICK_DIV, 50000000: clk_clk cycles per second; must be ≥ 4 and even.
- DEBOUNCE_CYC, 500000: cycles a synchronised button level must stay stable before it is accepted.
- BUZZ_W, 10: buzzer bus width.
- ALARM_SECS, 60: seconds the alarm sounds before self-silencing.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- button_i  in  4  raw keys, active-low: [0] mode, [1] field select, [2] increment, [3] alarm acknowledge.
- switch_i  in  2  [0] 1 = 12 h display; [1] 1 = alarm enabled.
- digits_o  out  24  BCD digits: [3:0] sec ones, [7:4] sec tens, [11:8] min ones, [15:12] min tens, [19:16] hour ones, [23:20] hour tens.
- blank_o  out  6  per-digit blank flag, bit order as digits_o.
- buzzer_o  out  BUZZ_W  buzzer drive; all bits carry the same value.
- alarm_active_o  out  1  alarm currently sounding.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset clears all state:
  - time 00:00:00, alarm 00:00, state RUN, field HOUR, prescaler 0;
  - digits_o 0, blank_o 0, buzzer_o 0, alarm_active_o 0;
  - debouncers treat buttons as released.
- Button input path:
  - Each button uses a 2-FF synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYC consecutive equal samples.
  - A press event is a 1-cycle pulse on the debounced 1->0 transition.
  - Holding a button yields exactly one event.
- Simultaneous press events: priority is mode > select > increment, and only the highest is acted on that cycle. Acknowledge is independent of this priority.
- Prescaler: counts 0..TICK_DIV-1 and wraps. sec_tick is asserted when the count equals TICK_DIV-1. The prescaler runs in every state.
- Time counting, on sec_tick, in RUN and SET_ALARM:
  - seconds 59->00 carries into minutes;
  - minutes 59->00 carries into hours;
  - hours 23->00.
  - All fields are held in BCD; each digit stays in range 0..9.
- FSM states: RUN, SET_TIME, SET_ALARM.
  - The mode event steps RUN->SET_TIME->SET_ALARM->RUN.
  - Entering either SET state sets the field to HOUR.
  - Entering SET_TIME forces seconds to 00 and freezes counting. Counting resumes on the next sec_tick after leaving.
- Field selection and increment:
  - The select event toggles the field between HOUR and MIN.
  - The increment event adds 1 to the selected field of the edited register (time in SET_TIME, alarm in SET_ALARM).
  - The increment wraps with no carry: hour 23->00, min 59->00.
  - Increment and select are ignored in RUN.
- Display:
  - RUN and SET_TIME show the time; SET_ALARM shows the alarm as HH:MM:00.
  - When switch_i[0]=1, the hour is converted for display only: 00->12, 13..23->01..11, 12 unchanged. Internal time stays 24 h.
  - Outputs are registered, giving 1 cycle of latency from a state change.
- Blinking: in the SET states, the two blank_o bits of the selected field are 1 while prescaler ≥ TICK_DIV/2. blank_o is otherwise 0, and always 0 in RUN.
- Alarm trigger:
  - In RUN with switch_i[1]=1, the sec_tick whose updated time equals alarm HH:MM:00 sets alarm_active_o on the following cycle.
  - It also loads a remaining-seconds counter with ALARM_SECS.
- Alarm while active:
  - buzzer_o is all ones while prescaler < TICK_DIV/2, otherwise all zeros (a 1 Hz chirp).
  - The remaining-seconds counter decrements on each sec_tick.
- Alarm clear: the alarm stops (alarm_active_o=0, buzzer_o=0 on the next cycle) on any of:
  - an acknowledge event;
  - the counter reaching 0;
  - switch_i[1]=0;
  - leaving RUN.
- Re-trigger: the alarm cannot re-trigger until the next match, 24 h later. Acknowledging on the same cycle as a trigger leaves the alarm inactive.
- Reset mid-alarm or mid-set returns immediately to the reset state.

Test Plan (TICK_DIV=10, DEBOUNCE_CYC=4, ALARM_SECS=3):
- Reset, then 10 cycles -> digits_o=0x000001. Run to 86400 ticks -> wraps to 0x000000. Pass through 00:00:59 -> next tick 0x000100.
- Glitchy button (low 2 cycles, high, low 10 cycles) -> exactly one press event, occurring 4 stable cycles after the final low edge plus 2 synchroniser cycles.
- Mode; increment ×25 -> hour reads 01. Select; increment ×61 -> min reads 01, hour still 01, seconds 00 and frozen. Mode ×2 back to RUN -> counting resumes from 01:01:00.
- Alarm set 00:01 with switch_i[1]=1; run to 00:01:00 -> alarm_active_o=1, buzzer_o=0x3FF for 5 of each 10 cycles. Self-clears after 3 ticks, at 00:01:03.
- Repeat, but acknowledge 1 tick after trigger -> buzzer_o=0 next cycle. Also clearing switch_i[1] during the alarm -> cleared.
- switch_i[0]=1 at 00:xx -> hour digits 1,2. At 13:xx -> 0,1. Assert reset mid-alarm -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/bcd_alarm_clock_core.sv
// Time-of-day clock with alarm: debounced keys, BCD HH:MM:SS counting, set modes,
// 12/24 h display, field blinking and a self-silencing 1 Hz buzzer.
module bcd_alarm_clock_core #(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter int unsigned BUZZ_W       = 10,
    parameter int unsigned ALARM_SECS   = 60
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [3:0]        button_i,
    input  logic [1:0]        switch_i,
    output logic [23:0]       digits_o,
    output logic [5:0]        blank_o,
    output logic [BUZZ_W-1:0] buzzer_o,
    output logic              alarm_active_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned AW = $clog2(ALARM_SECS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {StRun, StSetTime, StSetAlarm} state_e;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [3:0]    r_sync1, r_sync2, r_db;
    logic [DW-1:0] r_db_cnt [4];
    logic [3:0]    w_accept, w_press;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_accept[i] = (r_sync2[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST);
            w_press[i]  = w_accept[i] & r_db[i];
        end
    end

    // Buttons are active-low, so "released" is the reset level everywhere on this path.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_db    <= 4'hF;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= button_i;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_db_cnt[i] <= '0;
                    r_db[i]     <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic w_ev_mode, w_ev_sel, w_ev_inc, w_ev_ack;
    assign w_ev_mode = w_press[0];
    assign w_ev_sel  = w_press[1] & ~w_press[0];
    assign w_ev_inc  = w_press[2] & ~w_press[1] & ~w_press[0];
    assign w_ev_ack  = w_press[3];

    logic [PW-1:0] r_presc, w_presc_d;
    logic          w_tick;
    assign w_tick    = (r_presc == PRESC_MAX);
    assign w_presc_d = w_tick ? '0 : r_presc + PW'(1);

    state_e     r_state, w_state_d;
    logic       r_field_min, w_field_min_d;
    logic [7:0] r_sec, r_min, r_hr, r_al_min, r_al_hr;
    logic [7:0] w_sec_d, w_min_d, w_hr_d, w_al_min_d, w_al_hr_d;

    always_comb begin
        w_state_d     = r_state;
        w_field_min_d = r_field_min;
        if (w_ev_mode) begin
            w_field_min_d = 1'b0;
            case (r_state)
                StRun:     w_state_d = StSetTime;
                StSetTime: w_state_d = StSetAlarm;
                default:   w_state_d = StRun;
            endcase
        end else if (w_ev_sel && r_state != StRun) begin
            w_field_min_d = ~r_field_min;
        end
    end

    // Entering SET_TIME wins over a coincident tick: seconds clear and counting stops.
    always_comb begin
        w_sec_d    = r_sec;
        w_min_d    = r_min;
        w_hr_d     = r_hr;
        w_al_min_d = r_al_min;
        w_al_hr_d  = r_al_hr;
        if (r_state == StRun && w_ev_mode) begin
            w_sec_d = 8'h00;
        end else if (w_tick && r_state != StSetTime) begin
            w_sec_d = bcd_inc(r_sec, 8'h59);
            if (r_sec == 8'h59) begin
                w_min_d = bcd_inc(r_min, 8'h59);
                if (r_min == 8'h59) w_hr_d = bcd_inc(r_hr, 8'h23);
            end
        end else if (r_state == StSetTime && w_ev_inc) begin
            if (r_field_min) w_min_d = bcd_inc(r_min, 8'h59);
            else w_hr_d = bcd_inc(r_hr, 8'h23);
        end
        if (r_state == StSetAlarm && w_ev_inc) begin
            if (r_field_min) w_al_min_d = bcd_inc(r_al_min, 8'h59);
            else w_al_hr_d = bcd_inc(r_al_hr, 8'h23);
        end
    end

    logic          r_active, w_active_d, w_trig, w_clear;
    logic [AW-1:0] r_rem, w_rem_d;

    assign w_trig  = (r_state == StRun) && switch_i[1] && w_tick &&
                     ({w_hr_d, w_min_d, w_sec_d} == {r_al_hr, r_al_min, 8'h00});
    assign w_clear = w_ev_ack || !switch_i[1] || (r_state != StRun) || w_ev_mode;

    always_comb begin
        w_active_d = r_active;
        w_rem_d    = r_rem;
        if (w_clear) begin
            w_active_d = 1'b0;
        end else if (w_trig) begin
            w_active_d = 1'b1;
            w_rem_d    = AW'(ALARM_SECS);
        end else if (r_active && w_tick) begin
            w_rem_d = r_rem - AW'(1);
            if (r_rem == AW'(1)) w_active_d = 1'b0;
        end
    end

    logic [7:0] w_disp_hr, w_disp_min, w_disp_sec, w_hr_out;
    logic [4:0] w_h24, w_h12;
    logic [5:0] w_blank;

    always_comb begin
        w_disp_hr  = (r_state == StSetAlarm) ? r_al_hr : r_hr;
        w_disp_min = (r_state == StSetAlarm) ? r_al_min : r_min;
        w_disp_sec = (r_state == StSetAlarm) ? 8'h00 : r_sec;
        w_h24      = 5'(w_disp_hr[7:4]) * 5'd10 + 5'(w_disp_hr[3:0]);
        if (w_h24 == 5'd0) w_h12 = 5'd12;
        else if (w_h24 > 5'd12) w_h12 = w_h24 - 5'd12;
        else w_h12 = w_h24;
        if (!switch_i[0]) w_hr_out = w_disp_hr;
        else if (w_h12 >= 5'd10) w_hr_out = {4'd1, 4'(w_h12 - 5'd10)};
        else w_hr_out = {4'd0, w_h12[3:0]};
        w_blank = 6'b000000;
        if (r_state != StRun && r_presc >= PRESC_HALF) begin
            w_blank = r_field_min ? 6'b001100 : 6'b110000;
        end
    end

    logic [23:0]       r_digits;
    logic [5:0]        r_blank;
    logic [BUZZ_W-1:0] r_buzz;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_presc     <= '0;
            r_state     <= StRun;
            r_field_min <= 1'b0;
            r_sec       <= 8'h00;
            r_min       <= 8'h00;
            r_hr        <= 8'h00;
            r_al_min    <= 8'h00;
            r_al_hr     <= 8'h00;
            r_active    <= 1'b0;
            r_rem       <= '0;
            r_digits    <= '0;
            r_blank     <= '0;
            r_buzz      <= '0;
        end else begin
            r_presc     <= w_presc_d;
            r_state     <= w_state_d;
            r_field_min <= w_field_min_d;
            r_sec       <= w_sec_d;
            r_min       <= w_min_d;
            r_hr        <= w_hr_d;
            r_al_min    <= w_al_min_d;
            r_al_hr     <= w_al_hr_d;
            r_active    <= w_active_d;
            r_rem       <= w_rem_d;
            r_digits    <= {w_hr_out, w_disp_min, w_disp_sec};
            r_blank     <= w_blank;
            // Buzzer follows the next alarm state so it silences together with alarm_active_o.
            r_buzz      <= {BUZZ_W{w_active_d && (w_presc_d < PRESC_HALF)}};
        end
    end

    assign digits_o       = r_digits;
    assign blank_o        = r_blank;
    assign buzzer_o       = r_buzz;
    assign alarm_active_o = r_active;

endmodule

// File: tb/tb_bcd_alarm_clock_core.sv
// Scoreboard bench: a seconds-of-day reference model predicts every output cycle from the
// raw key/switch waveforms; a monitor pops and compares on each falling edge.
module tb_bcd_alarm_clock_core;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int AS = 3;
    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    btn = 4'hF;
    logic [1:0]    sw  = 2'b00;
    logic [23:0]   digits;
    logic [5:0]    blank;
    logic [BW-1:0] buzz;
    logic          act;

    bcd_alarm_clock_core #(
        .TICK_DIV    (TD),
        .DEBOUNCE_CYC(DB),
        .BUZZ_W      (BW),
        .ALARM_SECS  (AS)
    ) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .button_i      (btn),
        .switch_i      (sw),
        .digits_o      (digits),
        .blank_o       (blank),
        .buzzer_o      (buzz),
        .alarm_active_o(act)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]   d;
        logic [5:0]    b;
        logic [BW-1:0] z;
        logic          a;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: time in seconds of day, alarm in minutes of day.
    int         m_presc, m_tod, m_alarm, m_st, m_fld, m_rem;
    bit         m_act;
    logic [3:0] m_lvl;
    logic [3:0] m_hist[$];

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int hr12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_presc = 0; m_tod = 0; m_alarm = 0; m_st = 0; m_fld = 0; m_rem = 0; m_act = 0;
        m_lvl = 4'hF;
        m_hist.delete();
        for (int i = 0; i < DB + 2; i++) m_hist.push_back(4'hF);
    endtask

    task automatic model_step();
        int presc0, tod0, al0, st0, fld0, h, mi, s, dh, dm, ds;
        bit tick, e_mode, e_sel, e_inc, e_ack, clr, trig;
        logic [3:0] ev;
        exp_t e;
        // Key is accepted once the last DB synchronised samples (raw delayed 2) all disagree.
        m_hist.push_front(btn);
        void'(m_hist.pop_back());
        ev = 4'b0000;
        for (int b = 0; b < 4; b++) begin
            bit all_diff;
            all_diff = 1;
            for (int k = 2; k < DB + 2; k++) if (m_hist[k][b] == m_lvl[b]) all_diff = 0;
            if (all_diff) begin
                if (m_lvl[b]) ev[b] = 1'b1;
                m_lvl[b] = ~m_lvl[b];
            end
        end
        e_mode = ev[0];
        e_sel  = ev[1] && !ev[0];
        e_inc  = ev[2] && !ev[1] && !ev[0];
        e_ack  = ev[3];

        presc0 = m_presc; tod0 = m_tod; al0 = m_alarm; st0 = m_st; fld0 = m_fld;
        tick    = (presc0 == TD - 1);
        m_presc = (presc0 + 1) % TD;

        if (st0 == 0 && e_mode) begin
            m_tod = tod0 - tod0 % 60;
        end else if (tick && st0 != 1) begin
            m_tod = (tod0 + 1) % 86400;
        end else if (st0 == 1 && e_inc) begin
            h = tod0 / 3600; mi = (tod0 / 60) % 60; s = tod0 % 60;
            if (fld0 == 0) h = (h + 1) % 24;
            else mi = (mi + 1) % 60;
            m_tod = h * 3600 + mi * 60 + s;
        end
        if (st0 == 2 && e_inc) begin
            if (fld0 == 0) m_alarm = ((al0 / 60 + 1) % 24) * 60 + al0 % 60;
            else m_alarm = (al0 / 60) * 60 + (al0 % 60 + 1) % 60;
        end
        if (e_mode) begin
            m_st  = (st0 + 1) % 3;
            m_fld = 0;
        end else if (e_sel && st0 != 0) begin
            m_fld = 1 - fld0;
        end

        clr  = e_ack || !sw[1] || st0 != 0 || e_mode;
        trig = st0 == 0 && sw[1] && tick && m_tod == al0 * 60;
        if (clr) begin
            m_act = 0;
        end else if (trig) begin
            m_act = 1;
            m_rem = AS;
        end else if (m_act && tick) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_act = 0;
        end

        dh = (st0 == 2) ? al0 / 60 : tod0 / 3600;
        dm = (st0 == 2) ? al0 % 60 : (tod0 / 60) % 60;
        ds = (st0 == 2) ? 0 : tod0 % 60;
        if (sw[0]) dh = hr12(dh);
        e.d = {to_bcd(dh), to_bcd(dm), to_bcd(ds)};
        e.b = 6'b000000;
        if (st0 != 0 && presc0 >= TD / 2) e.b = (fld0 != 0) ? 6'b001100 : 6'b110000;
        e.z = {BW{m_act && m_presc < TD / 2}};
        e.a = m_act;
        q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({digits, blank, buzz, act} !== e) begin
                    n_miss++;
                    $display("FAIL outputs @%0t: got digits=%h blank=%b buzz=%h act=%b, expected digits=%h blank=%b buzz=%h act=%b",
                             $time, digits, blank, buzz, act, e.d, e.b, e.z, e.a);
                end
            end
        end
    end

    // Asynchronous reset must clear every output without waiting for a clock edge.
    initial begin
        forever begin
            @(posedge rst);
            #1;
            if ($time > 50) begin
                n_vec++;
                if ({digits, blank, buzz, act} !== '0) begin
                    n_miss++;
                    $display("FAIL async_reset: got digits=%h blank=%b buzz=%h act=%b, expected all zero",
                             digits, blank, buzz, act);
                end
            end
        end
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        @(negedge clk);
        btn[b] = 1'b0;
        negs(7);
        btn[b] = 1'b1;
        negs(7);
    endtask

    task automatic incs(input int n);
        repeat (n) press(2);
    endtask

    task automatic set_time(input int h, input int mi);
        press(0);
        incs((h - m_tod / 3600 + 24) % 24);
        press(1);
        incs((mi - (m_tod / 60) % 60 + 60) % 60);
        press(0);
        press(0);
    endtask

    task automatic set_alarm_soon();
        int t;
        press(0);
        press(0);
        t = (m_tod / 60 + 2) % 1440;
        incs((t / 60 - m_alarm / 60 + 24) % 24);
        press(1);
        incs((t % 60 - m_alarm % 60 + 60) % 60);
        press(0);
    endtask

    task automatic wait_alarm(input int budget);
        int k;
        k = 0;
        while (act !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (act !== 1'b1) begin
            n_vec++;
            n_miss++;
            $display("FAIL alarm_wait: alarm_active_o=%b after %0d cycles, required 1", act, budget);
        end
    endtask

    initial begin
        logic [3:0] mask;
        negs(3);
        rst = 1'b0;
        negs(25);

        // Glitch then a long hold on mode: a single event into SET_TIME.
        @(negedge clk);
        btn[0] = 1'b0; negs(2);
        btn[0] = 1'b1; negs(1);
        btn[0] = 1'b0; negs(10);
        btn[0] = 1'b1; negs(7);
        incs(25);
        press(1);
        incs(61);
        press(0);
        press(0);
        negs(40);

        set_time(23, 59);
        sw[0] = 1'b1;
        negs(700);

        sw[1] = 1'b1;
        set_alarm_soon();
        wait_alarm(3000);
        negs(60);

        set_alarm_soon();
        wait_alarm(3000);
        negs(10);
        press(3);
        negs(20);

        set_alarm_soon();
        wait_alarm(3000);
        negs(12);
        sw[1] = 1'b0;
        negs(10);
        sw[1] = 1'b1;

        set_time(13, 5);
        negs(30);

        set_alarm_soon();
        wait_alarm(3000);
        negs(7);
        #2;
        rst = 1'b1;
        negs(3);
        rst = 1'b0;
        negs(10);

        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: press($urandom_range(0, 3));
                3: begin
                    int b;
                    b = $urandom_range(0, 3);
                    @(negedge clk);
                    btn[b] = 1'b0;
                    negs($urandom_range(1, DB + 1));
                    btn[b] = 1'b1;
                    negs($urandom_range(1, 8));
                end
                4: begin
                    int s;
                    s = $urandom_range(0, 1);
                    sw[s] = ~sw[s];
                    negs($urandom_range(1, 5));
                end
                5: negs($urandom_range(1, 40));
                6: begin
                    mask = 4'($urandom_range(1, 15));
                    @(negedge clk);
                    btn = ~mask;
                    negs($urandom_range(3, 12));
                    btn = 4'hF;
                    negs(8);
                end
                default: begin
                    repeat (6) begin
                        @(negedge clk);
                        btn = 4'($urandom);
                    end
                    btn = 4'hF;
                    negs(8);
                end
            endcase
        end

        negs(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
